// File: rtl/count_capture_fifo.sv
// Snapshot FIFO for the 2-bit counter stage: captures count_in on each event strobe
// and presents the snapshots on a registered valid/ready port, with drop accounting.
module count_capture_fifo #(
  parameter int CW    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] count_in,
  input  logic          capture,
  input  logic          ovf_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [DW-1:0] drop_cnt
);

  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   level_nxt;
  logic          push;
  logic          pop;
  logic          drop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    pop       = out_valid && out_ready;
    push      = capture && (!full || pop);
    drop      = capture && full && !pop;
    rd_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + 1'b1;
    else if (pop && !push)
      level_nxt = level - 1'b1;
  end

  // storage is don't-care after reset, so it carries no reset term
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= count_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      // the new head may be the entry being written on this same edge
      if (level_nxt != '0)
        out_data <= (push && (wr_ptr == rd_nxt)) ? count_in : mem[rd_nxt];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clr)
        drop_cnt <= DW'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed and randomised-backpressure bench for count_capture_fifo with a queue model.
module tb_count_capture_fifo;
  localparam int CW = 2, DEPTH = 4, AW = 2, DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] count_in;
  logic          capture, ovf_clr, out_ready;
  logic          out_valid, full, empty, overflow;
  logic [CW-1:0] out_data;
  logic [AW:0]   level;
  logic [DW-1:0] drop_cnt;

  count_capture_fifo #(.CW(CW), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .capture(capture),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .level(level), .full(full), .empty(empty),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int mq[$];
  int popped[$];
  bit m_ovf;
  int m_drop;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock with the given inputs; model updated and outputs compared after the edge
  task automatic cycle(input bit cap, input int val, input bit rdy, input bit clr);
    bit pop, push, drop, stall;
    int held;
    capture   = cap;
    count_in  = val[CW-1:0];
    out_ready = rdy;
    ovf_clr   = clr;
    pop   = (mq.size() > 0) && rdy;
    push  = cap && ((mq.size() < DEPTH) || pop);
    drop  = cap && (mq.size() == DEPTH) && !pop;
    stall = (mq.size() > 0) && !rdy;
    held  = int'(out_data);
    @(posedge clk); #1;
    if (pop) begin
      popped.push_back(mq[0]);
      void'(mq.pop_front());
    end
    if (push) mq.push_back(val % 4);
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    chk("out_valid", int'(out_valid), int'(mq.size() > 0));
    chk("level", int'(level), mq.size());
    chk("full", int'(full), int'(mq.size() == DEPTH));
    chk("empty", int'(empty), int'(mq.size() == 0));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("drop_cnt", int'(drop_cnt), m_drop);
    if (mq.size() > 0) chk("out_data", int'(out_data), mq[0]);
    if (stall) chk("stall_stable", int'(out_data), held);
    capture = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int exp3[5];
    int exp5[4];
    exp3 = '{0, 1, 2, 3, 0};
    exp5 = '{2, 3, 0, 3};
    reset = 1'b0; capture = 1'b0; count_in = '0; ovf_clr = 1'b0; out_ready = 1'b0;
    m_ovf = 1'b0; m_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    reset = 1'b1;
    cycle(1'b0, 0, 1'b0, 1'b0);

    // latency: push into empty FIFO is visible one edge later
    cycle(1'b1, 2, 1'b0, 1'b0);
    chk("t2_valid", int'(out_valid), 1);
    chk("t2_data", int'(out_data), 2);
    chk("t2_level", int'(level), 1);
    drain();
    chk("t2_popped", popped[0], 2);

    // ordering with pointer wrap
    popped.delete();
    cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b1, 1, 1'b1, 1'b0);
    cycle(1'b1, 2, 1'b1, 1'b0);
    cycle(1'b1, 3, 1'b1, 1'b0);
    cycle(1'b1, 0, 1'b1, 1'b0);
    drain();
    chk("t3_count", popped.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) chk("t3_order", popped[i], exp3[i]);

    // overflow with stalled reader
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    cycle(1'b1, 3, 1'b0, 1'b0);
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    chk("t4_full", int'(full), 1);
    chk("t4_level", int'(level), 4);
    chk("t4_ovf", int'(overflow), 1);
    chk("t4_drop", int'(drop_cnt), 2);
    chk("t4_head", int'(out_data), 1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    chk("t4_clr_ovf", int'(overflow), 0);
    chk("t4_clr_drop", int'(drop_cnt), 0);

    // clear and drop on the same edge: the drop wins
    cycle(1'b1, 2, 1'b0, 1'b1);
    chk("clrdrop_ovf", int'(overflow), 1);
    chk("clrdrop_cnt", int'(drop_cnt), 1);
    cycle(1'b0, 0, 1'b0, 1'b1);

    // full FIFO, capture with simultaneous pop: accepted, no drop
    popped.delete();
    cycle(1'b1, 3, 1'b1, 1'b0);
    chk("t5_level", int'(level), 4);
    chk("t5_drop", int'(drop_cnt), 0);
    chk("t5_ovf", int'(overflow), 0);
    drain();
    chk("t5_count", popped.size(), 5);
    chk("t5_first", popped[0], 1);
    for (int i = 0; i < 4; i++)
      if (i + 1 < popped.size()) chk("t5_order", popped[i+1], exp5[i]);

    // drop counter saturation
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(1'b1, i, 1'b0, 1'b0);
    chk("sat_drop", int'(drop_cnt), 255);
    cycle(1'b0, 0, 1'b0, 1'b1);
    chk("sat_clr", int'(drop_cnt), 0);
    drain();

    // random backpressure; the per-cycle model compare is the scoreboard
    for (int i = 0; i < 200; i++)
      cycle(1'(($urandom_range(0, 3)) != 0), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'b0);
    drain();
    cycle(1'b0, 0, 1'b0, 1'b1);

    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 6; i++) cycle(1'b1, i, 1'b0, 1'b0);
    #3 reset = 1'b0;
    #1;
    chk("t1_valid", int'(out_valid), 0);
    chk("t1_empty", int'(empty), 1);
    chk("t1_level", int'(level), 0);
    chk("t1_ovf", int'(overflow), 0);
    chk("t1_drop", int'(drop_cnt), 0);
    mq.delete();
    m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    cycle(1'b1, 3, 1'b0, 1'b0);
    chk("post_rst_data", int'(out_data), 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
